// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   Parametrised up/down counter with a programmable modulo limit (range 0..limit),
//   programmable step, wrap or saturate at the boundaries, synchronous load and a
//   registered one-cycle boundary-event pulse plus a sticky overflow flag.
//
// Configuration macro:
//   MOD_COUNTER_SAT_EN  defined   -> sat_mode input selects saturate (1) or wrap (0)
//                       undefined -> sat_mode ignored, counter always wraps
//
// Ports:
//   clk        in   single clock, all state updates on posedge
//   rst        in   synchronous active-high reset
//   load_n     in   active-low synchronous load of min(data_load, limit)
//   ce         in   count enable
//   up_down    in   1 = count up, 0 = count down
//   data_load  in   [WIDTH]  load value
//   step       in   [STEP_W] increment/decrement amount (clamped to limit)
//   limit      in   [WIDTH]  upper bound of counting range
//   sat_mode   in   saturate instead of wrap (only with MOD_COUNTER_SAT_EN)
//   count_out  out  [WIDTH]  registered count
//   max_count  out  count_out == limit (combinational)
//   zero       out  count_out == 0 (combinational)
//   wrap       out  registered pulse: boundary crossed or clamped on last update
//   ovf_sticky out  registered; set by any wrap, cleared by rst or load

module mod_updown_counter #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_n,
    input  logic              ce,
    input  logic              up_down,
    input  logic [WIDTH-1:0]  data_load,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero,
    output logic              wrap,
    output logic              ovf_sticky
);

    localparam int unsigned CW = (WIDTH > STEP_W) ? WIDTH : STEP_W;
    localparam int unsigned W1 = WIDTH + 1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic             sat_en;

`ifdef MOD_COUNTER_SAT_EN
    assign sat_en = sat_mode;
`else
    // Port kept for interface compatibility; wrap mode is fixed.
    logic unused_sat_mode;
    assign unused_sat_mode = sat_mode;
    assign sat_en          = 1'b0;
`endif

    // Step and limit compared at a common width so any STEP_W/WIDTH mix works.
    logic [CW-1:0] step_cw, limit_cw;
    logic [W1-1:0] eff_step;
    logic [W1-1:0] cnt_x, lim_x, sum_up, sum_wrap_dn;

    assign step_cw  = CW'(step);
    assign limit_cw = CW'(limit);
    // When step <= limit the step fits in WIDTH bits, so the narrowing cast is lossless.
    assign eff_step = (step_cw > limit_cw) ? {1'b0, limit} : W1'(step_cw);

    assign cnt_x       = {1'b0, count_q};
    assign lim_x       = {1'b0, limit};
    assign sum_up      = cnt_x + eff_step;
    // Only used when eff_step > count, and eff_step <= limit, so never negative.
    assign sum_wrap_dn = cnt_x + lim_x + W1'(1) - eff_step;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (!load_n) begin
            count_d = (data_load > limit) ? limit : data_load;
            ovf_d   = 1'b0;
        end else begin
            if (ce) begin
                if (count_q > limit) begin
                    // Limit was lowered below the current count: pull back into range.
                    count_d = limit;
                    wrap_d  = 1'b1;
                end else if (eff_step == '0) begin
                    count_d = count_q;
                end else if (up_down) begin
                    if (sum_up > lim_x) begin
                        wrap_d  = 1'b1;
                        count_d = sat_en ? limit : WIDTH'(sum_up - lim_x - W1'(1));
                    end else begin
                        count_d = WIDTH'(sum_up);
                    end
                end else begin
                    if (cnt_x >= eff_step) begin
                        count_d = WIDTH'(cnt_x - eff_step);
                    end else begin
                        wrap_d  = 1'b1;
                        count_d = sat_en ? '0 : WIDTH'(sum_wrap_dn);
                    end
                end
            end
            ovf_d = ovf_q | wrap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_out  = count_q;
    assign wrap       = wrap_q;
    assign ovf_sticky = ovf_q;
    assign max_count  = (count_q == limit);
    assign zero       = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_n = 1'b1;
    logic       ce = 1'b0;
    logic       up_down = 1'b1;
    logic [3:0] data_load = 4'd0;
    logic [3:0] step = 4'd1;
    logic [3:0] limit = 4'd15;
    logic       sat_mode = 1'b0;
    logic [3:0] count_out;
    logic       max_count, zero, wrap, ovf_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       w;
        logic       o;
        logic       mx;
        logic       zr;
    } exp_t;

    exp_t exp_q[$];

    mod_updown_counter #(.WIDTH(4), .STEP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_n     (load_n),
        .ce         (ce),
        .up_down    (up_down),
        .data_load  (data_load),
        .step       (step),
        .limit      (limit),
        .sat_mode   (sat_mode),
        .count_out  (count_out),
        .max_count  (max_count),
        .zero       (zero),
        .wrap       (wrap),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    // Inputs are already set for the coming posedge; record the expected state after it.
    task automatic cyc(input string nm, input logic [3:0] c, input logic w, input logic o);
        exp_t e;
        e.name = nm;
        e.cnt  = c;
        e.w    = w;
        e.o    = o;
        e.mx   = (c == limit);
        e.zr   = (c == 4'd0);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input string fld, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s got %0d required %0d", nm, fld, act, req);
        end
    endtask

    // Monitor: the DUT presents a new state after every posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.name, "count", int'(count_out), int'(e.cnt));
                chk(e.name, "wrap", int'(wrap), int'(e.w));
                chk(e.name, "ovf", int'(ovf_sticky), int'(e.o));
                chk(e.name, "max", int'(max_count), int'(e.mx));
                chk(e.name, "zero", int'(zero), int'(e.zr));
            end
        end
    end

    initial begin
        // Reset
        cyc("reset", 4'd0, 1'b0, 1'b0);
        rst = 1'b0; load_n = 1'b0; data_load = 4'd9;
        cyc("load9", 4'd9, 1'b0, 1'b0);
        // Reset beats load and count
        rst = 1'b1; load_n = 1'b0; ce = 1'b1;
        cyc("rst_prio", 4'd0, 1'b0, 1'b0);

        // Up by 1 through the limit, wrap to 0
        rst = 1'b0; load_n = 1'b1; ce = 1'b1; up_down = 1'b1; step = 4'd1; limit = 4'd9;
        for (int i = 1; i <= 9; i++) cyc("up1", 4'(i), 1'b0, 1'b0);
        cyc("up_wrap", 4'd0, 1'b1, 1'b1);
        ce = 1'b0;
        cyc("hold", 4'd0, 1'b0, 1'b1);

        // Down wrap: 1 - 3 mod 10 = 8
        load_n = 1'b0; data_load = 4'd1;
        cyc("load1", 4'd1, 1'b0, 1'b0);
        load_n = 1'b1; ce = 1'b1; step = 4'd3; up_down = 1'b0;
        cyc("dn_wrap", 4'd8, 1'b1, 1'b1);
        ce = 1'b0;
        cyc("dn_hold", 4'd8, 1'b0, 1'b1);

        // Up overflow with sat_mode requested
        limit = 4'd15; load_n = 1'b0; data_load = 4'd14;
        cyc("load14", 4'd14, 1'b0, 1'b0);
        load_n = 1'b1; ce = 1'b1; step = 4'd4; up_down = 1'b1; sat_mode = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
        cyc("up_sat", 4'd15, 1'b1, 1'b1);
`else
        cyc("up_sat", 4'd2, 1'b1, 1'b1);
`endif
        sat_mode = 1'b0;

        // Load clamps to limit, load beats ce
        load_n = 1'b0; ce = 1'b1; data_load = 4'd12; limit = 4'd9;
        cyc("load_clamp", 4'd9, 1'b0, 1'b0);

        // Limit lowered below count, then step larger than limit
        limit = 4'd15; data_load = 4'd12;
        cyc("load12", 4'd12, 1'b0, 1'b0);
        load_n = 1'b1; ce = 1'b1; up_down = 1'b1; step = 4'd1; limit = 4'd5;
        cyc("oor_clamp", 4'd5, 1'b1, 1'b1);
        step = 4'd7;
        cyc("big_step", 4'd4, 1'b1, 1'b1);
        ce = 1'b0;
        cyc("hold2", 4'd4, 1'b0, 1'b1);

        // Exact landings are not wraps
        limit = 4'd9; load_n = 1'b0; data_load = 4'd6;
        cyc("load6", 4'd6, 1'b0, 1'b0);
        load_n = 1'b1; ce = 1'b1; up_down = 1'b0; step = 4'd3;
        cyc("dn3", 4'd3, 1'b0, 1'b0);
        cyc("dn_to0", 4'd0, 1'b0, 1'b0);
        cyc("dn_wrap2", 4'd7, 1'b1, 1'b1);
        up_down = 1'b1; step = 4'd2;
        cyc("up_to_lim", 4'd9, 1'b0, 1'b1);
        step = 4'd0;
        cyc("step0", 4'd9, 1'b0, 1'b1);

        // Down underflow with sat_mode requested
        load_n = 1'b0; data_load = 4'd1;
        cyc("load1b", 4'd1, 1'b0, 1'b0);
        load_n = 1'b1; up_down = 1'b0; step = 4'd3; sat_mode = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
        cyc("dn_sat", 4'd0, 1'b1, 1'b1);
`else
        cyc("dn_sat", 4'd8, 1'b1, 1'b1);
`endif
        sat_mode = 1'b0;

        // limit = 0: clamp into range, then eff_step = 0 holds
        limit = 4'd15; load_n = 1'b0; data_load = 4'd4;
        cyc("load4", 4'd4, 1'b0, 1'b0);
        load_n = 1'b1; ce = 1'b1; up_down = 1'b1; step = 4'd3; limit = 4'd0;
        cyc("lim0_clamp", 4'd0, 1'b1, 1'b1);
        cyc("lim0_hold", 4'd0, 1'b0, 1'b1);

        ce = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain pending %0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
